stopwatch_ctrl: RTL and testbench

Controller that sequences the seconds-timebase for the lab stopwatch. It owns a free-running prescaler that derives 1 Hz and 2 Hz tick enables from clk. A run/pause/adjust FSM gates those ticks into a BCD MM:SS counter. Outputs feed the 7-segment display mux directly; all outputs are registered.

---
 rtl/stopwatch_ctrl.sv | 120 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch timebase: free-running 1 Hz / 2 Hz prescaler, run/pause/adjust FSM
// and a BCD MM:SS counter. All outputs are registered.
module stopwatch_ctrl #(
   parameter int CYCLES_PER_SEC = 4,
   parameter int CNT_W          = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_pause,
   input  logic       btn_rst,
   input  logic       adj,
   input  logic       sel,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       blink
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_PAUSE  = 2'd2;
   localparam logic [1:0] S_ADJUST = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_SEC - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLES_PER_SEC / 2 - 1);

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] count;
   logic             tick_1hz, tick_2hz;
   logic [3:0]       mt_n, mo_n, st_n, so_n;
   logic             c0, c1, c2, c3;

   assign tick_1hz = (count == CNT_LAST);
   assign tick_2hz = tick_1hz || (count == CNT_HALF);

   // Returns {wrapped, next digit}; a digit at its limit wraps to 0.
   function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic [3:0] lim);
      bcd_inc = (d == lim) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
   endfunction

   // btn_rst is handled in the register block; adj outranks btn_pause here.
   always_comb begin
      state_nxt = state;
      if (adj)
         state_nxt = S_ADJUST;
      else if (state == S_ADJUST)
         state_nxt = S_PAUSE;
      else if (btn_pause) begin
         case (state)
            S_IDLE, S_PAUSE: state_nxt = S_RUN;
            S_RUN:           state_nxt = S_PAUSE;
            default:         state_nxt = state;
         endcase
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      mt_n = min_tens;
      mo_n = min_ones;
      st_n = sec_tens;
      so_n = sec_ones;
      c0   = 1'b0;
      c1   = 1'b0;
      c2   = 1'b0;
      c3   = 1'b0;
      if (state == S_RUN && tick_1hz) begin
         {c0, so_n} = bcd_inc(sec_ones, 4'd9);
         if (c0) begin
            {c1, st_n} = bcd_inc(sec_tens, 4'd5);
            if (c1) begin
               {c2, mo_n} = bcd_inc(min_ones, 4'd9);
               if (c2)
                  {c3, mt_n} = bcd_inc(min_tens, 4'd9);
            end
         end
      end else if (state == S_ADJUST && tick_2hz) begin
         if (sel) begin
            {c0, so_n} = bcd_inc(sec_ones, 4'd9);
            if (c0)
               {c1, st_n} = bcd_inc(sec_tens, 4'd5);
         end else begin
            {c2, mo_n} = bcd_inc(min_ones, 4'd9);
            if (c2)
               {c3, mt_n} = bcd_inc(min_tens, 4'd9);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset || btn_rst) begin
         min_tens <= 4'd0;
         min_ones <= 4'd0;
         sec_tens <= 4'd0;
         sec_ones <= 4'd0;
         count    <= '0;
         state    <= S_IDLE;
         running  <= 1'b0;
         blink    <= 1'b1;
      end else begin
         min_tens <= mt_n;
         min_ones <= mo_n;
         sec_tens <= st_n;
         sec_ones <= so_n;
         count    <= tick_1hz ? '0 : count + CNT_W'(1);
         state    <= state_nxt;
         running  <= (state_nxt == S_RUN);
         if (state_nxt != S_ADJUST || state != S_ADJUST)
            blink <= 1'b1;
         else if (tick_2hz)
            blink <= ~blink;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a seconds-based reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_stopwatch_ctrl;

   localparam int CPS = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0, btn_pause = 1'b0, btn_rst = 1'b0, adj = 1'b0, sel = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, blink;

   int n_cmp  = 0;
   int n_fail = 0;

   stopwatch_ctrl #(.CYCLES_PER_SEC(CPS), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .btn_pause(btn_pause), .btn_rst(btn_rst),
      .adj(adj), .sel(sel),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .running(running), .blink(blink)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int dut_time();
      return min_tens * 1000 + min_ones * 100 + sec_tens * 10 + sec_ones;
   endfunction

   // Reference model: time kept as minutes/seconds integers.
   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_ADJUST} mstate_t;
   mstate_t m_state, m_next;
   int      m_min, m_sec, m_cnt, m_total;
   bit      m_run, m_blink, m_valid = 1'b0, t1, t2;

   always @(posedge clk) begin
      if (reset) begin
         m_valid = 1'b1;
         m_min = 0; m_sec = 0; m_cnt = 0; m_state = M_IDLE; m_run = 0; m_blink = 1;
      end else if (m_valid && btn_rst) begin
         m_min = 0; m_sec = 0; m_cnt = 0; m_state = M_IDLE; m_run = 0; m_blink = 1;
      end else if (m_valid) begin
         t1 = (m_cnt == CPS - 1);
         t2 = t1 || (m_cnt == CPS / 2 - 1);
         if (m_state == M_RUN && t1) begin
            m_total = (m_min * 60 + m_sec + 1) % 6000;
            m_min = m_total / 60;
            m_sec = m_total % 60;
         end else if (m_state == M_ADJUST && t2) begin
            if (sel) m_sec = (m_sec + 1) % 60;
            else     m_min = (m_min + 1) % 100;
         end
         if (adj)                     m_next = M_ADJUST;
         else if (m_state == M_ADJUST) m_next = M_PAUSE;
         else if (btn_pause)          m_next = (m_state == M_RUN) ? M_PAUSE : M_RUN;
         else                         m_next = m_state;
         if (m_next != M_ADJUST || m_state != M_ADJUST) m_blink = 1;
         else if (t2)                                   m_blink = ~m_blink;
         m_state = m_next;
         m_run   = (m_state == M_RUN);
         m_cnt   = (m_cnt + 1) % CPS;
      end
      #1;
      if (m_valid) begin
         check("model_time", dut_time(), (m_min / 10) * 1000 + (m_min % 10) * 100
                                         + (m_sec / 10) * 10 + (m_sec % 10));
         check("model_running", int'(running), int'(m_run));
         check("model_blink", int'(blink), int'(m_blink));
         check("bcd_range", int'(min_tens <= 9 && min_ones <= 9 && sec_tens <= 5
                                 && sec_ones <= 9), 1);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      btn_pause = 0; btn_rst = 0; adj = 0; sel = 0;
      reset = 1;
      cycles(2);
      reset = 0;
   endtask

   task automatic pulse_pause();
      btn_pause = 1;
      cycles(1);
      btn_pause = 0;
   endtask

   initial begin
      @(negedge clk);

      // Idle after reset
      do_reset();
      cycles(20);
      check("idle_time", dut_time(), 0);
      check("idle_running", int'(running), 0);
      check("idle_blink", int'(blink), 1);

      // Run 240 cycles: 60 ticks -> 01:00
      do_reset();
      pulse_pause();
      check("run_started", int'(running), 1);
      cycles(239);
      check("run_one_min", dut_time(), 100);
      check("run_running", int'(running), 1);

      // Pause at 00:05, resume, next tick -> 00:06
      do_reset();
      pulse_pause();
      cycles(19);
      check("pre_pause", dut_time(), 5);
      pulse_pause();
      cycles(40);
      check("paused_frozen", dut_time(), 5);
      check("paused_running", int'(running), 0);
      pulse_pause();
      cycles(1);
      check("resume_no_tick", dut_time(), 5);
      cycles(1);
      check("resume_tick", dut_time(), 6);

      // Adjust: seconds wrap, then minutes wrap, blink toggling
      do_reset();
      adj = 1; sel = 1;
      cycles(1);
      check("adj_enter_blink", int'(blink), 1);
      cycles(1);
      check("adj_first_tick", dut_time(), 1);
      check("adj_blink_toggle", int'(blink), 0);
      cycles(116);
      check("adj_sec_59", dut_time(), 59);
      cycles(2);
      check("adj_sec_wrap", dut_time(), 0);
      cycles(120);
      check("adj_sec_120", dut_time(), 0);
      check("adj_blink_even", int'(blink), 1);
      sel = 0;
      cycles(198);
      check("adj_min_99", dut_time(), 9900);
      cycles(2);
      check("adj_min_wrap", dut_time(), 0);
      adj = 0;
      cycles(1);
      check("adj_exit_blink", int'(blink), 1);
      check("adj_exit_running", int'(running), 0);

      // Preset 99:59, run one tick -> 00:00
      do_reset();
      adj = 1; sel = 0;
      cycles(198);
      sel = 1;
      cycles(118);
      check("preset", dut_time(), 9959);
      adj = 0;
      cycles(1);
      pulse_pause();
      cycles(1);
      check("preset_hold", dut_time(), 9959);
      cycles(1);
      check("full_wrap", dut_time(), 0);
      check("full_wrap_running", int'(running), 1);

      // btn_rst on a tick, adj+pause together, reset mid-adjust
      do_reset();
      pulse_pause();
      cycles(30);
      check("mid_run", dut_time(), 7);
      btn_rst = 1;
      cycles(1);
      btn_rst = 0;
      check("rst_time", dut_time(), 0);
      check("rst_running", int'(running), 0);
      adj = 1; sel = 1; btn_pause = 1;
      cycles(1);
      btn_pause = 0;
      check("adj_over_pause_running", int'(running), 0);
      check("adj_over_pause_blink", int'(blink), 1);
      cycles(3);
      check("adj_after_rst", dut_time(), 2);
      reset = 1; adj = 0;
      cycles(1);
      check("reset_mid_adj_time", dut_time(), 0);
      check("reset_mid_adj_blink", int'(blink), 1);
      check("reset_mid_adj_running", int'(running), 0);
      reset = 0;
      cycles(3);
      check("post_reset_idle", dut_time(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
